// File: rtl/quadrilatero_pkg.sv
// Systolic-array scheduler types: queued instruction, in-flight slot, register one-hot helper.
package quadrilatero_pkg;
  localparam int SA_N_REGS = 8;
  localparam int SA_REG_W  = $clog2(SA_N_REGS);
  localparam int SA_ID_W   = xif_pkg::X_ID_WIDTH;

  typedef struct packed {
    logic [SA_REG_W-1:0] data_reg;
    logic [SA_REG_W-1:0] acc_reg;
    logic [SA_REG_W-1:0] weight_reg;
    logic [SA_ID_W-1:0]  id;
  } sa_instr_t;

  typedef struct packed {
    logic                valid;
    logic [SA_ID_W-1:0]  id;
    logic [SA_REG_W-1:0] acc_reg;
  } sa_slot_t;

  function automatic logic [SA_N_REGS-1:0] reg2onehot(input logic [SA_REG_W-1:0] r);
    reg2onehot    = '0;
    reg2onehot[r] = 1'b1;
  endfunction
endpackage

// File: rtl/xif_pkg.sv
// Coprocessor-interface constants shared with the scheduler (instruction id width).
package xif_pkg;
  localparam int X_ID_WIDTH = 4;
endpackage

// File: rtl/quadrilatero_sa_sched_fifo.sv
// Generic FIFO with full/empty flags; push is ignored when full, pop when empty.
// Simultaneous push and pop are supported; read data is the current head (no latency).
module quadrilatero_sa_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/quadrilatero_sa_scheduler.sv
// In-order SA issue scheduler: queue, accumulator/load hazard check, in-flight table retired by drain.
// QUADRILATERO_SA_SCHED_FINISH_BYPASS_EN lets a same-cycle finish free its slot for the pop decision.
module quadrilatero_sa_scheduler
  import quadrilatero_pkg::*;
#(
  parameter int N_REGS       = SA_N_REGS,
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              instr_valid_i,
  output logic                              instr_ready_o,
  input  logic [$clog2(N_REGS)-1:0]         instr_data_reg_i,
  input  logic [$clog2(N_REGS)-1:0]         instr_acc_reg_i,
  input  logic [$clog2(N_REGS)-1:0]         instr_weight_reg_i,
  input  logic [xif_pkg::X_ID_WIDTH-1:0]    instr_id_i,
  output logic                              issue_valid_o,
  input  logic                              issue_ready_i,
  output logic [$clog2(N_REGS)-1:0]         issue_data_reg_o,
  output logic [$clog2(N_REGS)-1:0]         issue_acc_reg_o,
  output logic [$clog2(N_REGS)-1:0]         issue_weight_reg_o,
  output logic [xif_pkg::X_ID_WIDTH-1:0]    issue_id_o,
  input  logic [N_REGS-1:0]                 ext_busy_i,
  input  logic                              finished_i,
  input  logic [xif_pkg::X_ID_WIDTH-1:0]    finished_id_i,
  output logic [N_REGS-1:0]                 acc_busy_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic                              idle_o,
  output logic                              err_o
);
  localparam int CW = $clog2(MAX_INFLIGHT+1);

  sa_instr_t in_instr, q_head, head, iss_q;
  logic      q_full, q_empty, q_push, q_pop;
  logic      iss_vld, head_vld, hazard, slot_free, pop, found, err_q;
  sa_slot_t [MAX_INFLIGHT-1:0] slots;
  logic [MAX_INFLIGHT-1:0]     fin_hit, live, alloc;
  logic [N_REGS-1:0]           busy_reg, busy_live, head_mask;
  logic [CW-1:0]               cnt;

  assign in_instr = '{data_reg: instr_data_reg_i, acc_reg: instr_acc_reg_i,
                      weight_reg: instr_weight_reg_i, id: instr_id_i};

  quadrilatero_sa_sched_fifo #(.WIDTH($bits(sa_instr_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(q_push), .wdata(in_instr),
    .pop(q_pop), .rdata(q_head), .full(q_full), .empty(q_empty)
  );

  always_comb begin
    fin_hit   = '0;
    live      = '0;
    busy_reg  = '0;
    busy_live = '0;
    cnt       = '0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      fin_hit[i] = finished_i && slots[i].valid && (slots[i].id == finished_id_i);
`ifdef QUADRILATERO_SA_SCHED_FINISH_BYPASS_EN
      live[i] = slots[i].valid && !fin_hit[i];
`else
      live[i] = slots[i].valid;
`endif
      if (slots[i].valid) busy_reg  = busy_reg | reg2onehot(slots[i].acc_reg);
      if (live[i])        busy_live = busy_live | reg2onehot(slots[i].acc_reg);
      cnt = cnt + CW'(slots[i].valid);
    end
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      if (!live[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
    slot_free = found;
    // An empty queue lets the arriving instruction go straight to the issue register.
    head      = q_empty ? in_instr : q_head;
    head_vld  = !q_empty || instr_valid_i;
    head_mask = reg2onehot(head.data_reg) | reg2onehot(head.acc_reg) | reg2onehot(head.weight_reg);
    hazard    = |(head_mask & (busy_live | ext_busy_i));
    pop       = head_vld && slot_free && !hazard && (!iss_vld || issue_ready_i);
    q_pop     = pop && !q_empty;
    q_push    = instr_valid_i && !q_full && !(pop && q_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slots   <= '0;
      iss_vld <= 1'b0;
      iss_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        if (fin_hit[i]) slots[i].valid <= 1'b0;
      end
      if (pop) begin
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
          if (alloc[i]) slots[i] <= '{valid: 1'b1, id: head.id, acc_reg: head.acc_reg};
        end
        iss_q   <= head;
        iss_vld <= 1'b1;
      end else if (issue_ready_i) begin
        iss_vld <= 1'b0;
      end
      if (finished_i && !(|fin_hit)) err_q <= 1'b1;
    end
  end

  assign instr_ready_o      = !q_full;
  assign issue_valid_o      = iss_vld;
  assign issue_data_reg_o   = iss_q.data_reg;
  assign issue_acc_reg_o    = iss_q.acc_reg;
  assign issue_weight_reg_o = iss_q.weight_reg;
  assign issue_id_o         = iss_q.id;
  assign acc_busy_o         = busy_reg;
  assign inflight_o         = cnt;
  assign idle_o             = q_empty && (cnt == '0);
  assign err_o              = err_q;
endmodule

// File: tb/tb_quadrilatero_sa_scheduler.sv
// Directed plus random bench for quadrilatero_sa_scheduler against a queue-based reference model.
module tb_quadrilatero_sa_scheduler;
  localparam int NR    = 8;
  localparam int DEPTH = 4;
  localparam int MAXI  = 2;
  localparam int IW    = xif_pkg::X_ID_WIDTH;
`ifdef QUADRILATERO_SA_SCHED_FINISH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          instr_valid_i, instr_ready_o;
  logic [2:0]    instr_data_reg_i, instr_acc_reg_i, instr_weight_reg_i;
  logic [IW-1:0] instr_id_i;
  logic          issue_valid_o, issue_ready_i;
  logic [2:0]    issue_data_reg_o, issue_acc_reg_o, issue_weight_reg_o;
  logic [IW-1:0] issue_id_o;
  logic [NR-1:0] ext_busy_i;
  logic          finished_i;
  logic [IW-1:0] finished_id_i;
  logic [NR-1:0] acc_busy_o;
  logic [1:0]    inflight_o;
  logic          idle_o, err_o;

  quadrilatero_sa_scheduler #(.N_REGS(NR), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_data_reg_i(instr_data_reg_i), .instr_acc_reg_i(instr_acc_reg_i),
    .instr_weight_reg_i(instr_weight_reg_i), .instr_id_i(instr_id_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_data_reg_o(issue_data_reg_o), .issue_acc_reg_o(issue_acc_reg_o),
    .issue_weight_reg_o(issue_weight_reg_o), .issue_id_o(issue_id_o),
    .ext_busy_i(ext_busy_i), .finished_i(finished_i), .finished_id_i(finished_id_i),
    .acc_busy_o(acc_busy_o), .inflight_o(inflight_o), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]    d, a, w;
    logic [IW-1:0] id;
  } ins_t;

  ins_t mq[$];
  ins_t mfl[$];
  ins_t m_iss;
  bit   m_iss_v, m_err;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [NR-1:0] oh(input logic [2:0] r);
    return NR'(1) << r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NR-1:0] b;
    b = '0;
    foreach (mfl[i]) b |= oh(mfl[i].a);
    chk("issue_valid", issue_valid_o, m_iss_v);
    if (m_iss_v) begin
      chk("issue_id", issue_id_o, m_iss.id);
      chk("issue_data", issue_data_reg_o, m_iss.d);
      chk("issue_acc", issue_acc_reg_o, m_iss.a);
      chk("issue_weight", issue_weight_reg_o, m_iss.w);
    end
    chk("instr_ready", instr_ready_o, mq.size() < DEPTH);
    chk("acc_busy", acc_busy_o, b);
    chk("inflight", inflight_o, mfl.size());
    chk("idle", idle_o, (mq.size() == 0) && (mfl.size() == 0));
    chk("err", err_o, m_err);
  endtask

  // One clock: model consumes the inputs present at the edge, then outputs are compared.
  task automatic step();
    ins_t          h, inc;
    logic [NR-1:0] busy, mask;
    int            cnt;
    bit            from_in, hv, elig, pop, push, hs, hit;
    @(posedge clk_i);
    inc = '{d: instr_data_reg_i, a: instr_acc_reg_i, w: instr_weight_reg_i, id: instr_id_i};
    hs  = m_iss_v && issue_ready_i;
    busy = '0;
    cnt  = 0;
    foreach (mfl[i]) begin
      if (!(BYP && finished_i && mfl[i].id == finished_id_i)) begin
        busy |= oh(mfl[i].a);
        cnt++;
      end
    end
    from_in = (mq.size() == 0);
    if (from_in) begin
      h  = inc;
      hv = instr_valid_i;
    end else begin
      h  = mq[0];
      hv = 1'b1;
    end
    mask = oh(h.d) | oh(h.a) | oh(h.w);
    elig = hv && (cnt < MAXI) && ((mask & (busy | ext_busy_i)) == '0);
    pop  = elig && (!m_iss_v || hs);
    push = instr_valid_i && (mq.size() < DEPTH) && !(pop && from_in);
    if (finished_i) begin
      hit = 1'b0;
      for (int i = mfl.size() - 1; i >= 0; i--) begin
        if (mfl[i].id == finished_id_i) begin
          mfl.delete(i);
          hit = 1'b1;
        end
      end
      if (!hit) m_err = 1'b1;
    end
    if (pop) begin
      if (!from_in) void'(mq.pop_front());
      m_iss   = h;
      m_iss_v = 1'b1;
      mfl.push_back(h);
    end else if (hs) begin
      m_iss_v = 1'b0;
    end
    if (push) mq.push_back(inc);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input int d, input int a, input int w, input int id);
    instr_valid_i      = v;
    instr_data_reg_i   = 3'(d);
    instr_acc_reg_i    = 3'(a);
    instr_weight_reg_i = 3'(w);
    instr_id_i         = IW'(id);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    issue_ready_i = 1'b0;
    ext_busy_i    = '0;
    finished_i    = 1'b0;
    finished_id_i = '0;
    rst_ni        = 1'b0;
    mq.delete();
    mfl.delete();
    m_iss   = '{default: '0};
    m_iss_v = 1'b0;
    m_err   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    int nid;
    do_reset();
    chk("rst_issue_valid", issue_valid_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_instr_ready", instr_ready_o, 1);
    chk("rst_err", err_o, 0);
    chk("rst_acc_busy", acc_busy_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_issue_id", issue_id_o, 0);
    chk("rst_issue_data", issue_data_reg_o, 0);

    // Back-to-back issue of ids 1 and 2.
    issue_ready_i = 1'b1;
    drive(1, 2, 0, 3, 1); step();
    chk("lat_id1_vld", issue_valid_o, 1);
    chk("lat_id1_id", issue_id_o, 1);
    drive(1, 4, 1, 5, 2); step();
    chk("b2b_id2_vld", issue_valid_o, 1);
    chk("b2b_id2_id", issue_id_o, 2);
    drive(0, 0, 0, 0, 0); step();
    chk("acc_busy_two", acc_busy_o, 8'b0000_0011);
    chk("inflight_two", inflight_o, 2);

    // RAW on r0: id 3 waits for id 1 to finish.
    finished_i = 1'b1; finished_id_i = IW'(2); step(); finished_i = 1'b0;
    chk("retire_id2", acc_busy_o, 8'b0000_0001);
    drive(1, 0, 6, 7, 3); step(); drive(0, 0, 0, 0, 0);
    chk("raw_block", issue_valid_o, 0);
    step();
    chk("raw_hold", issue_valid_o, 0);
    finished_i = 1'b1; finished_id_i = IW'(1); step(); finished_i = 1'b0;
    chk("raw_finish_cycle", issue_valid_o, BYP);
    step();
    chk("raw_after_finish", issue_valid_o, !BYP);

    // Load-unit busy on the head's weight register for 5 cycles.
    ext_busy_i = 8'h10;
    drive(1, 2, 1, 4, 4);
    for (int k = 0; k < 5; k++) begin
      step();
      drive(0, 0, 0, 0, 0);
      chk("ext_hold", issue_valid_o, 0);
    end
    ext_busy_i = '0;
    step();
    chk("ext_release_vld", issue_valid_o, 1);
    chk("ext_release_id", issue_id_o, 4);

    // Unknown finish id is sticky and leaves the table alone.
    issue_ready_i = 1'b0;
    finished_i = 1'b1; finished_id_i = IW'(7); step(); finished_i = 1'b0;
    chk("err_set", err_o, 1);
    chk("err_inflight", inflight_o, 2);
    step();
    chk("err_sticky", err_o, 1);

    // Fill the queue while the issue register is held.
    for (int k = 0; k < 4; k++) begin
      drive(1, 5, k, 6, 8 + k); step();
      chk("fill_ready", instr_ready_o, k < 3);
      chk("fill_stable_vld", issue_valid_o, 1);
      chk("fill_stable_id", issue_id_o, 4);
    end
    drive(1, 5, 0, 6, 12); step();
    chk("full_reject_ready", instr_ready_o, 0);
    drive(0, 0, 0, 0, 0);
    issue_ready_i = 1'b1; step();
    chk("release_hs", issue_valid_o, 0);

    // Random traffic.
    nid = 13;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), nid);
      nid++;
      issue_ready_i = ($urandom_range(0, 9) < 7);
      ext_busy_i    = NR'($urandom) & NR'($urandom) & NR'($urandom);
      finished_i    = 1'b0;
      if (mfl.size() > 0 && $urandom_range(0, 9) < 3) begin
        finished_i    = 1'b1;
        finished_id_i = mfl[$urandom_range(0, mfl.size() - 1)].id;
      end else if ($urandom_range(0, 49) == 0) begin
        finished_i    = 1'b1;
        finished_id_i = IW'($urandom);
      end
      step();
    end

    // Reset mid-operation drops state; a later finish is unknown.
    do_reset();
    chk("midrst_idle", idle_o, 1);
    chk("midrst_err", err_o, 0);
    chk("midrst_inflight", inflight_o, 0);
    finished_i = 1'b1; finished_id_i = IW'(5); step(); finished_i = 1'b0;
    chk("err_after_reset", err_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
